keypad_entry: RTL and testbench

Input-side counterpart of the seven-segment display driver: scans a 4×4 active-low matrix keypad by walking one column low at a time and reading the rows. It debounces presses and emits one key event per press. Decimal digits accumulate into an 8-bit entry that feeds the display value bus directly, and the committed value is handed to downstream logic.

---
 rtl/keypad_pkg.sv | 55 +++++
 rtl/keypad_if.sv | 24 ++
 rtl/keypad_scanner.sv | 100 ++++++++++
 rtl/keypad_entry.sv | 177 +++++++++++++++++
 tb/tb_keypad_entry.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad types: key codes, debounce FSM states,
// matrix lookup and entry arithmetic.
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_HELD,
    ST_RELEASE
  } state_t;

  function automatic logic [3:0] key_lookup(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] code;
    unique case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = KEY_A;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = KEY_B;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  // Shift in one decimal digit, clamping at 255.
  function automatic logic [7:0] entry_digit(
    input logic [7:0] e,
    input logic [3:0] d
  );
    logic [11:0] p;
    p = 12'(e) * 12'd10 + 12'(d);
    return (p > 12'd255) ? 8'hFF : p[7:0];
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pins plus entry/value result bus.
// slave: keypad_entry side; master: board/consumer side.
interface keypad_if;
  logic       enable;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [7:0] entry;
  logic [7:0] value;
  logic       value_valid;
  logic [3:0] key_code;
  logic       key_valid;

  modport master (
    output enable, key_row,
    input  key_col, entry, value,
    input  value_valid, key_code, key_valid
  );

  modport slave (
    input  enable, key_row,
    output key_col, entry, value,
    output value_valid, key_code, key_valid
  );
endinterface

// File: rtl/keypad_scanner.sv
// Column scanner: row sync, dwell/column counters,
// per-frame single-key detection.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_BITS = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       frm_valid,
  output logic       frm_key,
  output logic [3:0] frm_code
);

  logic [3:0]           row_s1;
  logic [3:0]           row_s2;
  logic [SCAN_BITS-1:0] dwell;
  logic [1:0]           col_sel;
  logic [1:0]           col_nxt;
  logic                 run;
  logic                 wrap;
  logic                 smp;
  logic [1:0]           acc_n;
  logic [3:0]           acc_code;
  logic [3:0]           lows;
  logic [2:0]           n_low;
  logic [2:0]           tot_raw;
  logic [1:0]           tot;
  logic [1:0]           low_row;
  logic [3:0]           this_code;

  assign wrap    = &dwell;
  assign smp     = run & wrap;
  assign col_nxt = col_sel + 2'(wrap);

  always_comb begin
    lows    = ~row_s2;
    n_low   = 3'(lows[0]) + 3'(lows[1])
            + 3'(lows[2]) + 3'(lows[3]);
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (lows[i]) low_row = 2'(i);
    tot_raw = 3'(acc_n) + n_low;
    tot     = (tot_raw >= 3'd2) ? 2'd2 : tot_raw[1:0];
    this_code = key_lookup(low_row, col_sel);
  end

  assign frm_valid = smp && (col_sel == 2'd3);
  assign frm_key   = (tot == 2'd1);
  assign frm_code  = (acc_n == 2'd0) ? this_code : acc_code;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= key_row;
      row_s2 <= row_s1;
    end
  end

  // run gates the first cycle after enable so column 0 gets a full dwell.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell    <= '0;
      col_sel  <= 2'd0;
      run      <= 1'b0;
      key_col  <= 4'hF;
      acc_n    <= 2'd0;
      acc_code <= 4'h0;
    end else if (!enable) begin
      dwell    <= '0;
      col_sel  <= 2'd0;
      run      <= 1'b0;
      key_col  <= 4'hF;
      acc_n    <= 2'd0;
      acc_code <= 4'h0;
    end else if (!run) begin
      run     <= 1'b1;
      key_col <= 4'b1110;
    end else begin
      dwell   <= dwell + 1'b1;
      col_sel <= col_nxt;
      key_col <= ~(4'b0001 << col_nxt);
      if (smp) begin
        if (col_sel == 2'd3) begin
          acc_n    <= 2'd0;
          acc_code <= 4'h0;
        end else begin
          acc_n <= tot;
          if (acc_n == 2'd0) acc_code <= this_code;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: debounce FSM, digit entry
// with saturation, and commit of the entered value.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_BITS      = 13,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic clk,
  input logic rst,
  keypad_if.slave bus
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);
  localparam bit ONE_SHOT = (DEBOUNCE_SCANS == 1);

  logic       frm_valid;
  logic       frm_key;
  logic [3:0] frm_code;

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic [3:0] cnt_inc;
  logic [3:0] cand;
  logic [3:0] cand_n;
  logic       fire;

  logic [7:0] entry_q;
  logic [7:0] entry_n;
  logic [7:0] value_q;
  logic [7:0] value_n;
  logic [3:0] code_q;
  logic [3:0] code_n;
  logic       kv_q;
  logic       vv_q;
  logic       vv_n;

  keypad_scanner #(
    .SCAN_BITS (SCAN_BITS)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .enable    (bus.enable),
    .key_row   (bus.key_row),
    .key_col   (bus.key_col),
    .frm_valid (frm_valid),
    .frm_key   (frm_key),
    .frm_code  (frm_code)
  );

  assign cnt_inc = cnt + 4'd1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    fire    = 1'b0;
    if (!bus.enable) begin
      state_n = ST_IDLE;
      cnt_n   = 4'd0;
    end else if (frm_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (frm_key) begin
            cand_n = frm_code;
            if (ONE_SHOT) begin
              state_n = ST_HELD;
              cnt_n   = 4'd0;
              fire    = 1'b1;
            end else begin
              state_n = ST_PRESS;
              cnt_n   = 4'd1;
            end
          end
        end
        ST_PRESS: begin
          if (!frm_key) begin
            state_n = ST_IDLE;
            cnt_n   = 4'd0;
          end else if (frm_code != cand) begin
            cand_n = frm_code;
            cnt_n  = 4'd1;
          end else if (cnt_inc >= DEB) begin
            state_n = ST_HELD;
            cnt_n   = 4'd0;
            fire    = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        ST_HELD: begin
          if (!frm_key) begin
            if (ONE_SHOT) begin
              state_n = ST_IDLE;
            end else begin
              state_n = ST_RELEASE;
              cnt_n   = 4'd1;
            end
          end
        end
        ST_RELEASE: begin
          if (frm_key) begin
            state_n = ST_HELD;
            cnt_n   = 4'd0;
          end else if (cnt_inc >= DEB) begin
            state_n = ST_IDLE;
            cnt_n   = 4'd0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    entry_n = entry_q;
    value_n = value_q;
    code_n  = code_q;
    vv_n    = 1'b0;
    if (fire) begin
      code_n = cand_n;
      unique case (1'b1)
        (cand_n <= 4'd9): begin
          entry_n = entry_digit(entry_q, cand_n);
        end
        (cand_n == KEY_STAR): begin
          entry_n = 8'd0;
        end
        (cand_n == KEY_HASH): begin
          value_n = entry_q;
          vv_n    = 1'b1;
          entry_n = 8'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      cand  <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= 8'd0;
      value_q <= 8'd0;
      code_q  <= 4'd0;
      kv_q    <= 1'b0;
      vv_q    <= 1'b0;
    end else begin
      entry_q <= entry_n;
      value_q <= value_n;
      code_q  <= code_n;
      kv_q    <= fire;
      vv_q    <= vv_n;
    end
  end

  assign bus.entry       = entry_q;
  assign bus.value       = value_q;
  assign bus.key_code    = code_q;
  assign bus.key_valid   = kv_q;
  assign bus.value_valid = vv_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry with a matrix
// keypad model; events are checked as they appear.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] held = 16'h0;
  logic [3:0]  row_m;

  keypad_if bus ();

  keypad_entry #(
    .SCAN_BITS      (2),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_m = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !bus.key_col[c])
          row_m[r] = 1'b0;
  end
  assign bus.key_row = row_m;

  typedef struct {
    logic [3:0] code;
    logic [7:0] entry;
    logic       vv;
    logic [7:0] value;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_evt  = 0;
  int   n_push = 0;
  logic [7:0] m_entry = 8'd0;
  logic [7:0] m_value = 8'd0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int kpos(input logic [3:0] k);
    case (k)
      4'h0: return 13;
      4'h1: return 0;
      4'h2: return 1;
      4'h3: return 2;
      4'h4: return 4;
      4'h5: return 5;
      4'h6: return 6;
      4'h7: return 8;
      4'h8: return 9;
      4'h9: return 10;
      4'hA: return 3;
      4'hB: return 7;
      4'hC: return 11;
      4'hD: return 15;
      4'hE: return 12;
      default: return 14;
    endcase
  endfunction

  task automatic push_exp(input logic [3:0] k);
    exp_t e;
    int   t;
    e.vv = 1'b0;
    if (k <= 4'd9) begin
      t = int'(m_entry) * 10 + int'(k);
      m_entry = (t > 255) ? 8'd255 : 8'(t);
    end else if (k == 4'hE) begin
      m_entry = 8'd0;
    end else if (k == 4'hF) begin
      m_value = m_entry;
      m_entry = 8'd0;
      e.vv = 1'b1;
    end
    e.code  = k;
    e.entry = m_entry;
    e.value = m_value;
    q.push_back(e);
    n_push++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.key_valid) begin
        n_evt++;
        if (q.size() == 0) begin
          chk("evt_unexp", 32'(bus.key_valid), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("key_code", 32'(bus.key_code), 32'(e.code));
          chk("entry", 32'(bus.entry), 32'(e.entry));
          chk("vv", 32'(bus.value_valid), 32'(e.vv));
          if (e.vv)
            chk("value", 32'(bus.value), 32'(e.value));
        end
      end
      if (bus.value_valid && !bus.key_valid)
        chk("vv_orphan", 32'(bus.value_valid), 0);
    end
  end

  // Returns at the first negedge after column 0 is driven.
  task automatic next_frame();
    logic [3:0] p;
    for (int t = 0; t < 64; t++) begin
      p = bus.key_col;
      @(negedge clk);
      if (bus.key_col == 4'b1110 && p != 4'b1110)
        return;
    end
    chk("frame_to", 32'(bus.key_col), 32'hE);
  endtask

  task automatic press(input logic [3:0] k,
                       input bit glitch);
    int p;
    p = kpos(k);
    next_frame();
    push_exp(k);
    held[p] = 1'b1;
    next_frame();
    chk("lat_pre", 32'(bus.key_valid), 0);
    next_frame();
    chk("lat_evt", 32'(bus.key_valid), 1);
    if (glitch) begin
      held[p] = 1'b0;
      next_frame();
      held[p] = 1'b1;
      next_frame();
      next_frame();
      next_frame();
    end
    held[p] = 1'b0;
    next_frame();
    next_frame();
    next_frame();
  endtask

  initial begin
    logic [3:0] ec;
    bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(bus.key_col), 32'hF);
    chk("rst_entry", 32'(bus.entry), 0);
    chk("rst_value", 32'(bus.value), 0);
    chk("rst_code", 32'(bus.key_code), 0);
    chk("rst_kv", 32'(bus.key_valid), 0);
    chk("rst_vv", 32'(bus.value_valid), 0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ec = ~(4'b0001 << (i / 4));
      chk("scan_col", 32'(bus.key_col), 32'(ec));
    end
    chk("idle_entry", 32'(bus.entry), 0);

    press(4'h5, 1'b0);
    chk("entry5", 32'(bus.entry), 5);

    // Key 7 present only in alternating frames.
    next_frame();
    for (int i = 0; i < 3; i++) begin
      held[kpos(4'h7)] = 1'b1;
      next_frame();
      held[kpos(4'h7)] = 1'b0;
      next_frame();
    end
    press(4'h7, 1'b1);

    press(4'hE, 1'b0);
    press(4'h2, 1'b0);
    press(4'h5, 1'b0);
    press(4'h6, 1'b0);
    chk("entry_sat", 32'(bus.entry), 255);
    press(4'hF, 1'b0);
    chk("commit_val", 32'(bus.value), 255);
    chk("commit_ent", 32'(bus.entry), 0);
    press(4'h9, 1'b0);
    press(4'h9, 1'b0);
    press(4'h9, 1'b0);
    chk("entry999", 32'(bus.entry), 255);

    press(4'h4, 1'b0);
    next_frame();
    held[kpos(4'h1)] = 1'b1;
    held[kpos(4'h2)] = 1'b1;
    repeat (4) next_frame();
    held = 16'h0;
    repeat (3) next_frame();
    press(4'hE, 1'b0);
    chk("clr_entry", 32'(bus.entry), 0);
    press(4'hD, 1'b0);
    chk("d_code", 32'(bus.key_code), 32'hD);

    // Drop enable while debouncing key 3.
    next_frame();
    held[kpos(4'h3)] = 1'b1;
    next_frame();
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("en_off_col", 32'(bus.key_col), 32'hF);
    repeat (40) @(negedge clk);
    chk("en_off_col2", 32'(bus.key_col), 32'hF);
    push_exp(4'h3);
    bus.enable = 1'b1;
    next_frame();
    next_frame();
    chk("en_early", 32'(bus.key_valid), 0);
    next_frame();
    chk("en_evt", 32'(bus.key_valid), 1);
    held = 16'h0;
    repeat (3) next_frame();
    chk("en_entry", 32'(bus.entry), 3);

    next_frame();
    held[kpos(4'h8)] = 1'b1;
    next_frame();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_col", 32'(bus.key_col), 32'hF);
    chk("arst_entry", 32'(bus.entry), 0);
    chk("arst_value", 32'(bus.value), 0);
    chk("arst_code", 32'(bus.key_code), 0);
    held = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    chk("q_empty", 32'(q.size()), 0);
    chk("n_evt", 32'(n_evt), 32'(n_push));
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
